vga_timing_gen: RTL and testbench

- Pixel-timing source for the 640x480@60 display path; the driving end of the hCount/vCount/bright interface that the game block controller consumes.
- Divides the 100 MHz system clock to a 25 MHz pixel enable and runs the horizontal and vertical counters.
- Decodes sync and display-area signals, and registers the controller's returned rgb into blanked 4-bit VGA pins.
- Emits a once-per-frame tick that paces game-object motion.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pix_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, RGB444 pixel type and game colours
package vga_pkg;

  localparam int VGA_CLK_DIV      = 4;
  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_DISP_START = 144;
  localparam int VGA_H_DISP_END   = 783;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_DISP_START = 35;
  localparam int VGA_V_DISP_END   = 514;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t RED    = 12'hF00;
  localparam rgb444_t SHARK  = 12'h058;
  localparam rgb444_t BOTTLE = 12'hAEF;
  localparam rgb444_t SAND   = 12'hFF0;

  // Each bar index bit drives one whole colour channel fully on or off.
  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - system-clock divider producing a one-clock pixel enable
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pix_en = (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel counters, sync/colour output stage and frame tick
// Optional colour-bar test pattern under `VGA_TESTPAT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = VGA_CLK_DIV,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_DISP_START = VGA_H_DISP_START,
  parameter int H_DISP_END   = VGA_H_DISP_END,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_DISP_START = VGA_V_DISP_START,
  parameter int V_DISP_END   = VGA_V_DISP_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  input  logic        test_mode,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        frame_tick,
  output logic [7:0]  frame_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);
  localparam logic [9:0] H_DS   = 10'(H_DISP_START);
  localparam logic [9:0] H_DE   = 10'(H_DISP_END);
  localparam logic [9:0] V_DS   = 10'(V_DISP_START);
  localparam logic [9:0] V_DE   = 10'(V_DISP_END);

  logic    line_end;
  rgb444_t pix_rgb;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  assign line_end = (hCount == H_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  assign bright = (hCount >= H_DS) && (hCount <= H_DE) &&
                  (vCount >= V_DS) && (vCount <= V_DE);

  // Tick as the last visible line completes so motion updates land in vertical blank.
  assign frame_tick = pix_en && line_end && (vCount == V_DE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (frame_tick) begin
      frame_count <= frame_count + 1'b1;
    end
  end

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((hCount - H_DS) >> 6);
  assign pix_rgb = test_mode ? bar_colour(bar_idx) : rgb444_t'(rgb_in);
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_rgb = rgb_in;
`endif

  // Sync and colour share one register stage so they stay pixel-aligned at the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hSync              <= 1'b1;
      vSync              <= 1'b1;
      {vgaR, vgaG, vgaB} <= 12'h000;
    end else if (pix_en) begin
      hSync              <= !(hCount < H_SW);
      vSync              <= !(vCount < V_SW);
      {vgaR, vgaG, vgaB} <= bright ? pix_rgb : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen at full and reduced timing
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD      = (g == 0) ? 4   : 3;
    localparam int HT      = (g == 0) ? 800 : 40;
    localparam int HS      = (g == 0) ? 96  : 6;
    localparam int HDS     = (g == 0) ? 144 : 8;
    localparam int HDE     = (g == 0) ? 783 : 35;
    localparam int VT      = (g == 0) ? 525 : 16;
    localparam int VS      = 2;
    localparam int VDS     = (g == 0) ? 35  : 3;
    localparam int VDE     = (g == 0) ? 514 : 13;
    localparam int RST_PIX = (g == 0) ? (1 * 800 + 400) : (2 * 640 + 8 * 40 + 20);
    localparam int RUN_PIX = (g == 0) ? 2500 : 1920;
    localparam longint FRAME = longint'(HT) * VT;
    localparam logic [13:0] RESET_OUT = 14'h3000;

    logic        rst, test_mode, done;
    logic [11:0] rgb_in;
    logic        pix_en, bright, hSync, vSync, frame_tick;
    logic [9:0]  hCount, vCount;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic [7:0]  frame_count;

    if (g == 0) begin : g_inst
      vga_timing_gen dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .test_mode(test_mode),
        .pix_en(pix_en), .hCount(hCount), .vCount(vCount), .bright(bright),
        .hSync(hSync), .vSync(vSync), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
        .frame_tick(frame_tick), .frame_count(frame_count)
      );
    end else begin : g_inst
      vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_DISP_START(HDS),
        .H_DISP_END(HDE), .V_TOTAL(VT), .V_SYNC(VS), .V_DISP_START(VDS),
        .V_DISP_END(VDE)
      ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .test_mode(test_mode),
        .pix_en(pix_en), .hCount(hCount), .vCount(vCount), .bright(bright),
        .hSync(hSync), .vSync(vSync), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
        .frame_tick(frame_tick), .frame_count(frame_count)
      );
    end

    // Reference model: everything follows from clock edges seen since reset release.
    longint ecount;
    always @(posedge clk or posedge rst) begin
      if (rst) ecount <= 0;
      else     ecount <= ecount + 1;
    end

    function automatic int h_of(input longint p);
      return int'(p % HT);
    endfunction
    function automatic int v_of(input longint p);
      return int'((p / HT) % VT);
    endfunction
    function automatic bit vis(input longint p);
      return h_of(p) >= HDS && h_of(p) <= HDE && v_of(p) >= VDS && v_of(p) <= VDE;
    endfunction
    function automatic int frames(input longint p);
      longint tick_pix;
      tick_pix = longint'(VDE) * HT + HT - 1;
      if (p <= tick_pix) return 0;
      return int'(((p - 1 - tick_pix) / FRAME + 1) % 256);
    endfunction
    function automatic logic [13:0] out_of(input longint p, input logic [11:0] rgb);
      return {h_of(p) >= HS, v_of(p) >= VS, vis(p) ? rgb : 12'h000};
    endfunction

    logic [13:0] sb[$];

    task automatic drive_cycle();
      @(negedge clk);
      rgb_in    = 12'($urandom);
      test_mode = 1'($urandom);
      if (ecount % CD == CD - 1) sb.push_back(out_of(ecount / CD, rgb_in));
    endtask

    task automatic chk_reset(input string tag);
      chk($sformatf("g%0d_%s_hCount", g, tag), 32'(hCount), 0);
      chk($sformatf("g%0d_%s_vCount", g, tag), 32'(vCount), 0);
      chk($sformatf("g%0d_%s_hSync", g, tag), 32'(hSync), 1);
      chk($sformatf("g%0d_%s_vSync", g, tag), 32'(vSync), 1);
      chk($sformatf("g%0d_%s_vga", g, tag), 32'({vgaR, vgaG, vgaB}), 0);
      chk($sformatf("g%0d_%s_pix_en", g, tag), 32'(pix_en), 0);
      chk($sformatf("g%0d_%s_frame_tick", g, tag), 32'(frame_tick), 0);
      chk($sformatf("g%0d_%s_frame_count", g, tag), 32'(frame_count), 0);
    endtask

    initial begin
      rst = 1'b1;
      rgb_in = '0;
      test_mode = 1'b0;
      done = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;
      sb.push_back(RESET_OUT);
      do drive_cycle(); while (ecount / CD != RST_PIX || ecount % CD != 1);
      chk($sformatf("g%0d_prereset_hCount", g), 32'(hCount), 32'(RST_PIX % HT));
      rst = 1'b1;
      sb.delete();
      #1 chk_reset("mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb.push_back(RESET_OUT);
      repeat (RUN_PIX * CD) drive_cycle();
      done = 1'b1;
    end

    longint      last_tick;
    int          bcount;
    longint      p;
    bit          pix;
    logic [13:0] e;

    initial begin
      last_tick = -1;
      bcount = 0;
      forever begin
        @(posedge clk);
        #1;
        if (!done) begin
          if (rst) begin
            last_tick = -1;
            bcount = 0;
          end
          p   = ecount / CD;
          pix = (ecount % CD == CD - 1);
          chk($sformatf("g%0d_pix_en", g), 32'(pix_en), 32'(pix));
          chk($sformatf("g%0d_hCount", g), 32'(hCount), 32'(h_of(p)));
          chk($sformatf("g%0d_vCount", g), 32'(vCount), 32'(v_of(p)));
          chk($sformatf("g%0d_bright", g), 32'(bright), 32'(vis(p)));
          chk($sformatf("g%0d_frame_tick", g), 32'(frame_tick),
              32'(pix && h_of(p) == HT - 1 && v_of(p) == VDE));
          chk($sformatf("g%0d_frame_count", g), 32'(frame_count), 32'(frames(p)));
          if (pix_en === 1'b1) begin
            if (bright === 1'b1) bcount++;
            if (sb.size() == 0) begin
              chk($sformatf("g%0d_sb_underflow", g), 0, 1);
            end else begin
              e = sb.pop_front();
              chk($sformatf("g%0d_hSync", g), 32'(hSync), 32'(e[13]));
              chk($sformatf("g%0d_vSync", g), 32'(vSync), 32'(e[12]));
              chk($sformatf("g%0d_vga", g), 32'({vgaR, vgaG, vgaB}), 32'(e[11:0]));
            end
          end
          if (frame_tick === 1'b1) begin
            if (last_tick >= 0) begin
              chk($sformatf("g%0d_tick_period", g), 32'(ecount - last_tick), 32'(FRAME * CD));
              chk($sformatf("g%0d_bright_per_frame", g), 32'(bcount),
                  32'((HDE - HDS + 1) * (VDE - VDS + 1)));
            end
            last_tick = ecount;
            bcount = 0;
          end
        end
      end
    end
  end

  initial begin
    int c;
    c = 0;
    while (!(g_dut[0].done && g_dut[1].done) && c < 60000) begin
      @(posedge clk);
      c++;
    end
    chk("run_complete", 32'(g_dut[0].done && g_dut[1].done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
